dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the two CPU cores of the dual-core design.
- Each core raises a request when its decoded memread/memwrite is active in MEM stage, then stalls until acknowledged.
- Arbiter serialises accesses with round-robin priority and sequences a fixed-latency memory access.
- Sits between core MEM stages and the data memory instance.

---
 rtl/dmem_arbiter_pkg.sv | 13 +
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the dual-core data-memory arbiter: FSM encoding and core indices.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic CORE0 = 1'b0;
    localparam logic CORE1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two core MEM stages.
// Each granted access runs a fixed MEM_LAT-cycle memory window followed by a one-cycle ack.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              c0_req_i,
    input  logic              c0_we_i,
    input  logic [ADDR_W-1:0] c0_addr_i,
    input  logic [DATA_W-1:0] c0_wdata_i,
    output logic              c0_ack_o,
    output logic [DATA_W-1:0] c0_rdata_o,
    output logic              c0_stall_o,

    input  logic              c1_req_i,
    input  logic              c1_we_i,
    input  logic [ADDR_W-1:0] c1_addr_i,
    input  logic [DATA_W-1:0] c1_wdata_i,
    output logic              c1_ack_o,
    output logic [DATA_W-1:0] c1_rdata_o,
    output logic              c1_stall_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              owner_o
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t           state;
    logic             rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             any_req;
    logic             grant;

    // On a tie rr_ptr decides; otherwise whichever core is requesting wins.
    always_comb begin
        any_req = c0_req_i | c1_req_i;
        grant   = (c0_req_i && c1_req_i) ? rr_ptr : c1_req_i;
    end

    assign c0_stall_o = c0_req_i & ~c0_ack_o;
    assign c1_stall_o = c1_req_i & ~c1_ack_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            rr_ptr      <= CORE0;
            owner_o     <= CORE0;
            cnt         <= '0;
            c0_ack_o    <= 1'b0;
            c1_ack_o    <= 1'b0;
            c0_rdata_o  <= '0;
            c1_rdata_o  <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            c0_ack_o <= 1'b0;
            c1_ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_o     <= grant;
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= (grant == CORE1) ? c1_we_i    : c0_we_i;
                        mem_addr_o  <= (grant == CORE1) ? c1_addr_i  : c0_addr_i;
                        mem_wdata_o <= (grant == CORE1) ? c1_wdata_i : c0_wdata_i;
                        cnt         <= CNT_W'(MEM_LAT - 1);
                        state       <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        // mem_we_o doubles as the latched direction of the current access.
                        if (!mem_we_o) begin
                            if (owner_o == CORE1) c1_rdata_o <= mem_rdata_i;
                            else                  c0_rdata_o <= mem_rdata_i;
                        end
                        c0_ack_o <= (owner_o == CORE0);
                        c1_ack_o <= (owner_o == CORE1);
                        mem_en_o <= 1'b0;
                        mem_we_o <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    rr_ptr <= ~owner_o;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a fixed-latency memory model.
module tb_dmem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              c0_req_i = 1'b0, c0_we_i = 1'b0;
    logic [ADDR_W-1:0] c0_addr_i = '0;
    logic [DATA_W-1:0] c0_wdata_i = '0;
    logic              c1_req_i = 1'b0, c1_we_i = 1'b0;
    logic [ADDR_W-1:0] c1_addr_i = '0;
    logic [DATA_W-1:0] c1_wdata_i = '0;
    logic              c0_ack_o, c1_ack_o, c0_stall_o, c1_stall_o;
    logic [DATA_W-1:0] c0_rdata_o, c1_rdata_o;
    logic              mem_en_o, mem_we_o, owner_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .c0_req_i(c0_req_i), .c0_we_i(c0_we_i), .c0_addr_i(c0_addr_i), .c0_wdata_i(c0_wdata_i),
        .c0_ack_o(c0_ack_o), .c0_rdata_o(c0_rdata_o), .c0_stall_o(c0_stall_o),
        .c1_req_i(c1_req_i), .c1_we_i(c1_we_i), .c1_addr_i(c1_addr_i), .c1_wdata_i(c1_wdata_i),
        .c1_ack_o(c1_ack_o), .c1_rdata_o(c1_rdata_o), .c1_stall_o(c1_stall_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .owner_o(owner_o)
    );

    // Memory model: read data is only valid in the MEM_LAT-th enabled cycle.
    function automatic logic [31:0] rd_val(input logic [31:0] a);
        case (a)
            32'h20:  rd_val = 32'hCAFE_0020;
            32'h40:  rd_val = 32'hDEAD_BEEF;
            32'h80:  rd_val = 32'h0000_1234;
            default: rd_val = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    logic [3:0]  en_run = '0;
    logic [31:0] last_wr_addr = '0, last_wr_data = '0;

    always @(posedge clk) begin
        en_run <= mem_en_o ? en_run + 4'd1 : 4'd0;
        if (mem_en_o && mem_we_o) begin
            last_wr_addr <= mem_addr_o;
            last_wr_data <= mem_wdata_o;
        end
    end

    assign mem_rdata_i = (mem_en_o && !mem_we_o && en_run == 4'(MEM_LAT - 1))
                         ? rd_val(mem_addr_o) : 32'hBAD0_BAD0;

    task automatic idle_inputs();
        c0_req_i = 1'b0; c0_we_i = 1'b0; c0_addr_i = '0; c0_wdata_i = '0;
        c1_req_i = 1'b0; c1_we_i = 1'b0; c1_addr_i = '0; c1_wdata_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_en_o, mem_we_o, c0_ack_o, c1_ack_o, owner_o} !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: en/we/ack0/ack1/owner got %b want 00000", i,
                         {mem_en_o, mem_we_o, c0_ack_o, c1_ack_o, owner_o});
            end
        end
        n_checks++;
        if (c0_rdata_o !== '0 || c1_rdata_o !== '0 || mem_addr_o !== '0 || mem_wdata_o !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: rd0=%h rd1=%h addr=%h wdata=%h want all 0",
                     c0_rdata_o, c1_rdata_o, mem_addr_o, mem_wdata_o);
        end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        c0_req_i = 1'b1; c0_we_i = 1'b0; c0_addr_i = 32'h40;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_en_o, c0_ack_o, c1_ack_o} !== {(i == 1 || i == 2), (i == 3), 1'b0}) begin
                n_fail++;
                $display("FAIL single_read_timing cyc %0d: en/ack0/ack1 got %b want %b", i,
                         {mem_en_o, c0_ack_o, c1_ack_o}, {(i == 1 || i == 2), (i == 3), 1'b0});
            end
            if (i == 1) begin
                n_checks++;
                if (mem_addr_o !== 32'h40 || mem_we_o !== 1'b0 || c0_stall_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_read_issue: addr=%h we=%b stall=%b want 40/0/1",
                             mem_addr_o, mem_we_o, c0_stall_o);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (c0_rdata_o !== 32'hDEAD_BEEF || c0_stall_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_read_data: rdata=%h stall=%b want deadbeef/0",
                             c0_rdata_o, c0_stall_o);
                end
                c0_req_i = 1'b0;
            end
        end
        n_checks++;
        if (c1_rdata_o !== '0) begin
            n_fail++;
            $display("FAIL single_read_c1_untouched: c1_rdata=%h want 0", c1_rdata_o);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(negedge clk);
        c0_req_i = 1'b1; c0_we_i = 1'b1; c0_addr_i = 32'h10; c0_wdata_i = 32'h11;
        c1_req_i = 1'b1; c1_we_i = 1'b0; c1_addr_i = 32'h20;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_en_o, c0_ack_o, c1_ack_o, c1_stall_o} !==
                {(i == 1 || i == 2 || i == 5 || i == 6), (i == 3), (i == 7), (i < 7)}) begin
                n_fail++;
                $display("FAIL simult_timing cyc %0d: en/ack0/ack1/stall1 got %b want %b", i,
                         {mem_en_o, c0_ack_o, c1_ack_o, c1_stall_o},
                         {(i == 1 || i == 2 || i == 5 || i == 6), (i == 3), (i == 7), (i < 7)});
            end
            if (i == 1) begin
                n_checks++;
                if ({mem_we_o, owner_o} !== 2'b10 || mem_addr_o !== 32'h10 || mem_wdata_o !== 32'h11) begin
                    n_fail++;
                    $display("FAIL simult_c0_issue: we=%b owner=%b addr=%h wdata=%h want 1/0/10/11",
                             mem_we_o, owner_o, mem_addr_o, mem_wdata_o);
                end
            end
            if (i == 3) c0_req_i = 1'b0;
            if (i == 5) begin
                n_checks++;
                if ({mem_we_o, owner_o} !== 2'b01 || mem_addr_o !== 32'h20) begin
                    n_fail++;
                    $display("FAIL simult_c1_issue: we=%b owner=%b addr=%h want 0/1/20",
                             mem_we_o, owner_o, mem_addr_o);
                end
            end
            if (i == 7) begin
                n_checks++;
                if (c1_rdata_o !== 32'hCAFE_0020) begin
                    n_fail++;
                    $display("FAIL simult_c1_data: got %h want cafe0020", c1_rdata_o);
                end
                c1_req_i = 1'b0;
            end
        end
        n_checks++;
        if (last_wr_addr !== 32'h10 || last_wr_data !== 32'h11) begin
            n_fail++;
            $display("FAIL simult_write: mem[%h]=%h want mem[10]=11", last_wr_addr, last_wr_data);
        end
    endtask

    task automatic test_round_robin();
        int g = 0;
        int cyc = 0;
        do_reset();
        @(negedge clk);
        c0_req_i = 1'b1; c0_addr_i = 32'h100;
        c1_req_i = 1'b1; c1_addr_i = 32'h200;
        while (g < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (c0_ack_o || c1_ack_o) begin
                n_checks++;
                if ((c0_ack_o && c1_ack_o) || c1_ack_o !== 1'(g % 2)) begin
                    n_fail++;
                    $display("FAIL round_robin grant %0d: ack0=%b ack1=%b want core %0d",
                             g, c0_ack_o, c1_ack_o, g % 2);
                end
                g++;
            end
        end
        idle_inputs();
        n_checks++;
        if (g != 6) begin
            n_fail++;
            $display("FAIL round_robin_timeout: got %0d acks want 6", g);
        end
    endtask

    task automatic test_write_no_clobber();
        int cyc = 0;
        int we_cyc = 0;
        int bad_we = 0;
        @(negedge clk);
        c1_req_i = 1'b1; c1_we_i = 1'b0; c1_addr_i = 32'h80;
        while (!c1_ack_o && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (mem_we_o) bad_we++;
        end
        n_checks++;
        if (!c1_ack_o || c1_rdata_o !== 32'h0000_1234 || bad_we != 0) begin
            n_fail++;
            $display("FAIL clobber_read: ack=%b rdata=%h we_cycles=%0d want 1/00001234/0",
                     c1_ack_o, c1_rdata_o, bad_we);
        end
        c1_we_i = 1'b1; c1_addr_i = 32'h84; c1_wdata_i = 32'h5678;
        @(negedge clk);
        cyc = 0;
        while (!c1_ack_o && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (mem_we_o && mem_en_o) we_cyc++;
            if (mem_we_o && !mem_en_o) bad_we++;
        end
        c1_req_i = 1'b0; c1_we_i = 1'b0;
        n_checks++;
        if (!c1_ack_o || we_cyc != MEM_LAT || bad_we != 0) begin
            n_fail++;
            $display("FAIL clobber_we_window: ack=%b we_cycles=%0d stray=%0d want 1/%0d/0",
                     c1_ack_o, we_cyc, bad_we, MEM_LAT);
        end
        n_checks++;
        if (c1_rdata_o !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL clobber_rdata: got %h want 00001234", c1_rdata_o);
        end
        n_checks++;
        if (last_wr_addr !== 32'h84 || last_wr_data !== 32'h5678) begin
            n_fail++;
            $display("FAIL clobber_write: mem[%h]=%h want mem[84]=5678", last_wr_addr, last_wr_data);
        end
    endtask

    task automatic test_reset_mid_access();
        int cyc = 0;
        int stray = 0;
        @(negedge clk);
        c0_req_i = 1'b1; c0_we_i = 1'b0; c0_addr_i = 32'h40;
        while (!c0_ack_o && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        c0_req_i = 1'b0;
        @(negedge clk);
        c0_req_i = 1'b1; c0_addr_i = 32'h20;
        repeat (2) @(negedge clk);
        n_checks++;
        if (mem_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_setup: mem_en got %b want 1", mem_en_o);
        end
        rst_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_en_o, c0_ack_o} !== 2'b00 || c0_rdata_o !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_abort: en=%b ack0=%b rdata0=%h want 0/0/0",
                     mem_en_o, c0_ack_o, c0_rdata_o);
        end
        rst_i = 1'b0;
        c0_req_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (c0_ack_o || mem_en_o) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_ack: %0d cycles with ack/en got want 0", stray);
        end
        c0_req_i = 1'b1; c0_addr_i = 32'h100;
        c1_req_i = 1'b1; c1_addr_i = 32'h200;
        @(negedge clk);
        n_checks++;
        if ({mem_en_o, owner_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_mid_tie: en/owner got %b want 10", {mem_en_o, owner_o});
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_round_robin();
        test_write_no_clobber();
        test_reset_mid_access();
        repeat (6) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
